add_arb2: RTL and testbench

ADD_ARB2 -- requirements
Module: add_arb2

---
 rtl/add_arb2.sv | 198 +++++++++++++++++++
 tb/tb_add_arb2.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arb2.sv
// ---------------------------------------------------------------------------
// add_arb2 -- two-requester round-robin front end for one shared adder.
//
// Each requester offers operands (a, b, cin). One request is accepted at a
// time. It is presented to an external adder with ADD_LAT cycles of latency,
// and the result is held as a response until the consumer takes it.
//
// Parameters
//   N        operand / sum width
//   ADD_LAT  adder latency in cycles (1..15)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   r0_valid/r0_ready, r0_a, r0_b, r0_cin   requester 0
//   r1_valid/r1_ready, r1_a, r1_b, r1_cin   requester 1
//   add_a, add_b, add_cin       operands driven to the shared adder
//   add_s, add_cout             result returned by the shared adder
//   rsp_valid/rsp_ready, rsp_id, rsp_s, rsp_cout   response channel
//
// Optional feature (macro ADD_ARB_STATS_EN)
//   Defining the macro adds gnt0_cnt / gnt1_cnt. These are 16-bit saturating
//   counts of the grants accepted from each requester.
// ---------------------------------------------------------------------------
module add_arb2 #(
    parameter int N       = 32,
    parameter int ADD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    input  logic         r1_valid,
    output logic         r0_ready,
    output logic         r1_ready,
    input  logic [N-1:0] r0_a,
    input  logic [N-1:0] r0_b,
    input  logic         r0_cin,
    input  logic [N-1:0] r1_a,
    input  logic [N-1:0] r1_b,
    input  logic         r1_cin,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_s,
    input  logic         add_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_s,
    output logic         rsp_cout
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [15:0]  gnt0_cnt,
    output logic [15:0]  gnt1_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ADD_LAT);

    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;        // preferred requester under contention
    logic [3:0]   cnt_q, cnt_d;        // edges left until the adder result is valid
    logic         id_q, id_d;
    logic [N-1:0] s_q, s_d;
    logic         cout_q, cout_d;

    // The operand holding registers are pure data, so they carry no reset.
    // Outside IDLE the outputs are gated by state, which keeps them at 0
    // in IDLE and during reset.
    logic [N-1:0] a_q, b_q;
    logic         cin_q;

    logic         gnt_vld;
    logic         gnt_id;
    logic         capture;

    // Round-robin grant. This is evaluated only in IDLE, so ready is held
    // low while an operation is outstanding.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == S_IDLE) begin
            if (r0_valid && r1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ptr_q;
            end else if (r0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (r1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    // The counter is loaded with ADD_LAT on acceptance. Seeing 1 in WAIT
    // therefore marks the ADD_LAT-th edge after acceptance.
    assign capture = (state_q == S_WAIT) && (cnt_q <= 4'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            a_q   <= gnt_id ? r1_a   : r0_a;
            b_q   <= gnt_id ? r1_b   : r0_b;
            cin_q <= gnt_id ? r1_cin : r0_cin;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_LOAD;
                    id_d    = gnt_id;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (capture) begin
                    state_d = S_RESP;
                    s_d     = add_s;
                    cout_d  = add_cout;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    ptr_d   = ~id_q;       // favour the other requester next time
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        r0_ready  = gnt_vld & ~gnt_id;
        r1_ready  = gnt_vld &  gnt_id;
        add_a     = (state_q != S_IDLE) ? a_q   : '0;
        add_b     = (state_q != S_IDLE) ? b_q   : '0;
        add_cin   = (state_q != S_IDLE) ? cin_q : 1'b0;
        rsp_valid = (state_q == S_RESP);
        rsp_id    = id_q;
        rsp_s     = s_q;
        rsp_cout  = cout_q;
    end

`ifdef ADD_ARB_STATS_EN
    logic [15:0] gnt0_q, gnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_q <= 16'd0;
            gnt1_q <= 16'd0;
        end else begin
            if (gnt_vld && !gnt_id && (gnt0_q != 16'hFFFF))
                gnt0_q <= gnt0_q + 16'd1;
            if (gnt_vld && gnt_id && (gnt1_q != 16'hFFFF))
                gnt1_q <= gnt1_q + 16'd1;
        end
    end

    assign gnt0_cnt = gnt0_q;
    assign gnt1_cnt = gnt1_q;
`endif

endmodule

// File: tb/tb_add_arb2.sv
// ---------------------------------------------------------------------------
// tb_add_arb2 -- directed, self-checking bench for add_arb2.
//
// There are two instances. Index 0 uses ADD_LAT=1 and sees a combinational
// adder. Index 1 uses ADD_LAT=4 and sees an adder whose result appears
// ADD_LAT-1 registers after its operands. Expected responses are pushed to
// a per-instance queue when a grant is predicted, and popped when the
// response appears.
// Counter ports are checked when ADD_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_add_arb2;
    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         r0_valid [2];
    logic         r1_valid [2];
    logic         r0_ready [2];
    logic         r1_ready [2];
    logic [N-1:0] r0_a [2];
    logic [N-1:0] r0_b [2];
    logic [N-1:0] r1_a [2];
    logic [N-1:0] r1_b [2];
    logic         r0_cin [2];
    logic         r1_cin [2];
    logic [N-1:0] add_a [2];
    logic [N-1:0] add_b [2];
    logic         add_cin [2];
    logic [N-1:0] add_s [2];
    logic         add_cout [2];
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic         rsp_id [2];
    logic [N-1:0] rsp_s [2];
    logic         rsp_cout [2];
`ifdef ADD_ARB_STATS_EN
    logic [15:0]  gnt0_cnt [2];
    logic [15:0]  gnt1_cnt [2];
`endif

    add_arb2 #(.N(N), .ADD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid[0]), .r1_valid(r1_valid[0]),
        .r0_ready(r0_ready[0]), .r1_ready(r1_ready[0]),
        .r0_a(r0_a[0]), .r0_b(r0_b[0]), .r0_cin(r0_cin[0]),
        .r1_a(r1_a[0]), .r1_b(r1_b[0]), .r1_cin(r1_cin[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_s(add_s[0]), .add_cout(add_cout[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_id(rsp_id[0]), .rsp_s(rsp_s[0]), .rsp_cout(rsp_cout[0])
`ifdef ADD_ARB_STATS_EN
        , .gnt0_cnt(gnt0_cnt[0]), .gnt1_cnt(gnt1_cnt[0])
`endif
    );

    add_arb2 #(.N(N), .ADD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid[1]), .r1_valid(r1_valid[1]),
        .r0_ready(r0_ready[1]), .r1_ready(r1_ready[1]),
        .r0_a(r0_a[1]), .r0_b(r0_b[1]), .r0_cin(r0_cin[1]),
        .r1_a(r1_a[1]), .r1_b(r1_b[1]), .r1_cin(r1_cin[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_s(add_s[1]), .add_cout(add_cout[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_id(rsp_id[1]), .rsp_s(rsp_s[1]), .rsp_cout(rsp_cout[1])
`ifdef ADD_ARB_STATS_EN
        , .gnt0_cnt(gnt0_cnt[1]), .gnt1_cnt(gnt1_cnt[1])
`endif
    );

    // Shared adder models
    logic [N:0] sum0, sum1, p1a, p1b, p1c;
    assign sum0 = {1'b0, add_a[0]} + {1'b0, add_b[0]} + {{N{1'b0}}, add_cin[0]};
    assign add_s[0]    = sum0[N-1:0];
    assign add_cout[0] = sum0[N];

    assign sum1 = {1'b0, add_a[1]} + {1'b0, add_b[1]} + {{N{1'b0}}, add_cin[1]};
    always_ff @(posedge clk) begin
        p1a <= sum1;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign add_s[1]    = p1c[N-1:0];
    assign add_cout[1] = p1c[N];

    typedef struct packed {
        logic         id;
        logic [N-1:0] s;
        logic         cout;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks = 0;
    int   errors = 0;
    bit   ptr_m [2];
    int   gcnt [2][2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic void sb_push(input bit d, input exp_t e);
        if (d) sb1.push_back(e);
        else   sb0.push_back(e);
    endfunction

    function automatic int sb_size(input bit d);
        return d ? sb1.size() : sb0.size();
    endfunction

    function automatic exp_t sb_pop(input bit d);
        if (d) return sb1.pop_front();
        return sb0.pop_front();
    endfunction

    task automatic clear_inputs(input bit d);
        r0_valid[d] = 1'b0; r1_valid[d] = 1'b0;
        r0_a[d] = '0; r0_b[d] = '0; r0_cin[d] = 1'b0;
        r1_a[d] = '0; r1_b[d] = '0; r1_cin[d] = 1'b0;
        rsp_ready[d] = 1'b1;
    endtask

    task automatic set_req(input bit d, input bit who, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic c);
        if (who) begin
            r1_a[d] = a; r1_b[d] = b; r1_cin[d] = c; r1_valid[d] = 1'b1;
        end else begin
            r0_a[d] = a; r0_b[d] = b; r0_cin[d] = c; r0_valid[d] = 1'b1;
        end
    endtask

    task automatic chk_quiet(input bit d, input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'(0));
        chk({tag, "_rsp_s"},     64'(rsp_s[d]),     64'(0));
        chk({tag, "_rsp_id"},    64'(rsp_id[d]),    64'(0));
        chk({tag, "_rsp_cout"},  64'(rsp_cout[d]),  64'(0));
        chk({tag, "_add_a"},     64'(add_a[d]),     64'(0));
        chk({tag, "_add_b"},     64'(add_b[d]),     64'(0));
        chk({tag, "_add_cin"},   64'(add_cin[d]),   64'(0));
        chk({tag, "_r0_ready"},  64'(r0_ready[d]),  64'(0));
        chk({tag, "_r1_ready"},  64'(r1_ready[d]),  64'(0));
    endtask

    // The task is called at a negedge with requests already driven.
    // It predicts the grant, follows the operation to its response and, when
    // rsp_ready is high, completes the handshake and returns at the
    // following negedge.
    task automatic serve(input bit d, input bit keep, input int lat);
        bit           who;
        logic [N-1:0] a, b;
        logic         c;
        logic [N:0]   full;
        exp_t         e, got;
        int           n;
        who  = (r0_valid[d] && r1_valid[d]) ? ptr_m[d] : r1_valid[d];
        a    = who ? r1_a[d]   : r0_a[d];
        b    = who ? r1_b[d]   : r0_b[d];
        c    = who ? r1_cin[d] : r0_cin[d];
        full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        e.id = who; e.s = full[N-1:0]; e.cout = full[N];
        #1;
        chk("grant_r0_ready", 64'(r0_ready[d]), 64'(!who));
        chk("grant_r1_ready", 64'(r1_ready[d]), 64'(who));
        sb_push(d, e);
        gcnt[d][who]++;
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            if (who) r1_valid[d] = 1'b0;
            else     r0_valid[d] = 1'b0;
        end
        chk("wait_add_a",   64'(add_a[d]),   64'(a));
        chk("wait_add_b",   64'(add_b[d]),   64'(b));
        chk("wait_add_cin", 64'(add_cin[d]), 64'(c));
        chk("wait_r0_ready", 64'(r0_ready[d]), 64'(0));
        chk("wait_r1_ready", 64'(r1_ready[d]), 64'(0));
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(lat));
        if (rsp_valid[d] && sb_size(d) > 0) begin
            got = sb_pop(d);
            chk("rsp_id",   64'(rsp_id[d]),   64'(got.id));
            chk("rsp_s",    64'(rsp_s[d]),    64'(got.s));
            chk("rsp_cout", 64'(rsp_cout[d]), 64'(got.cout));
        end
        if (rsp_ready[d]) begin
            @(posedge clk);
            ptr_m[d] = !who;
            @(negedge clk);
            chk("rsp_valid_drop", 64'(rsp_valid[d]), 64'(0));
        end
    endtask

    task automatic chk_stats(input bit d);
`ifdef ADD_ARB_STATS_EN
        chk("gnt0_cnt", 64'(gnt0_cnt[d]), 64'(gcnt[d][0]));
        chk("gnt1_cnt", 64'(gnt1_cnt[d]), 64'(gcnt[d][1]));
`else
        chk("sb_drained", 64'(sb_size(d)), 64'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        clear_inputs(1'b0);
        clear_inputs(1'b1);
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
        gcnt[0][0] = 0; gcnt[0][1] = 0; gcnt[1][0] = 0; gcnt[1][1] = 0;
        repeat (3) @(negedge clk);
        chk_quiet(1'b0, "reset1");
        chk_quiet(1'b1, "reset4");
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from reset: grants alternate r0, r1, r0, r1
        for (int d = 0; d < 2; d++) begin
            set_req(d[0], 1'b0, 32'd100, 32'd200, 1'b0);
            set_req(d[0], 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
            chk("contention_first_ptr", 64'(ptr_m[d[0]]), 64'(0));
            repeat (4) serve(d[0], 1'b1, (d == 0) ? 1 : 4);
            r0_valid[d[0]] = 1'b0;
            r1_valid[d[0]] = 1'b0;
        end

        // Single request, r0: 5 + 7
        set_req(1'b0, 1'b0, 32'd5, 32'd7, 1'b0);
        serve(1'b0, 1'b0, 1);

        // Wrap, r1: FFFFFFFF + 0 + 1 -> 0, carry out
        set_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        serve(1'b0, 1'b0, 1);

        // Backpressure. r1 is left pending for the whole RESP stall.
        rsp_ready[0] = 1'b0;
        set_req(1'b0, 1'b1, 32'd9, 32'd10, 1'b0);
        set_req(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        ptr_m[0] = 1'b0;
        serve(1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'(1));
            chk("bp_rsp_s",     64'(rsp_s[0]),     64'(32'h2345_6789));
            chk("bp_r0_ready",  64'(r0_ready[0]),  64'(0));
            chk("bp_r1_ready",  64'(r1_ready[0]),  64'(0));
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        ptr_m[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_drop", 64'(rsp_valid[0]), 64'(0));
        serve(1'b0, 1'b0, 1);
        chk_stats(1'b0);

        // Reset while the ADD_LAT=4 instance is in WAIT
        set_req(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        #1;
        chk("rw_accept", 64'(r0_ready[1]), 64'(1));
        @(posedge clk);
        @(negedge clk);
        r0_valid[1] = 1'b0;
        chk("rw_in_wait_add_a", 64'(add_a[1]), 64'(3));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet(1'b1, "rw");
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
        gcnt[0][0] = 0; gcnt[0][1] = 0; gcnt[1][0] = 0; gcnt[1][1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen = 1'b1;
        end
        chk("rw_no_stale_rsp", 64'(seen), 64'(0));

        // The transaction after the reset is served normally. Five singles
        // follow: three from r0 and two from r1.
        set_req(1'b1, 1'b1, 32'd11, 32'd22, 1'b1);
        serve(1'b1, 1'b0, 4);
        set_req(1'b1, 1'b0, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
        serve(1'b1, 1'b0, 4);
        set_req(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd1, 1'b1);
        serve(1'b1, 1'b0, 4);
        set_req(1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        serve(1'b1, 1'b0, 4);
        set_req(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        serve(1'b1, 1'b0, 4);
        chk_stats(1'b1);
        chk("sb_empty", 64'(sb0.size() + sb1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
